// File: rtl/cnn_seq_pkg.sv
// Shared constants for the CNN layer sequencer: FSM state encoding,
// default layer count and the canonical layer indices.
package cnn_seq_pkg;

  // Sequencer state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RST   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  // Default number of layer engines and their execution-order indices
  localparam int DEF_N_LAYERS = 5;
  localparam int L_CONV1      = 0;
  localparam int L_POOL1      = 1;
  localparam int L_CONV2      = 2;
  localparam int L_POOL2      = 3;
  localparam int L_FC         = 4;

endpackage

// File: rtl/cnn_layer_seq_timer.sv
// Loadable up/down counter with a zero terminal flag. The sequencer uses it
// both to count down the soft-reset hold and to count up the RUN watchdog.
module seq_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement and increment are never requested together
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cnn_layer_seq.sv
// Layer scheduler: for each image, walks the layer engines in ascending
// order, giving each a soft-reset hold, a one-cycle start, then waiting for
// its done under a watchdog. A hung engine parks the sequencer in ERR with
// every engine held in reset until software clears the error.
module cnn_layer_seq
  import cnn_seq_pkg::*;
#(
  parameter int N_LAYERS = DEF_N_LAYERS,
  parameter int RST_CYC  = 10,
  parameter int TIMEOUT  = 1000000,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                err_clr,
  input  logic [N_LAYERS-1:0] layer_done,
  output logic [N_LAYERS-1:0] layer_rst,
  output logic [N_LAYERS-1:0] layer_start,
  output logic [IDX_W-1:0]    cur_layer,
  output logic                busy,
  output logic                frame_done,
  output logic                err,
  output logic [IDX_W-1:0]    err_layer
);

  // The timer must hold both TIMEOUT-1 and RST_CYC-1
  localparam int TW_TO = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam int TW_RC = ($clog2(RST_CYC) < 1) ? 1 : $clog2(RST_CYC);
  localparam int TW    = (TW_TO > TW_RC) ? TW_TO : TW_RC;

  localparam logic [TW-1:0]    RST_LOAD   = TW'(RST_CYC - 1);
  localparam logic [TW-1:0]    TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(N_LAYERS - 1);

  logic [2:0]          state_q, state_d;
  logic [N_LAYERS-1:0] layer_rst_q, layer_rst_d;
  logic [N_LAYERS-1:0] layer_start_q, layer_start_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_layer_q, err_layer_d;

  logic                tmr_load, tmr_inc, tmr_dec, tmr_zero;
  logic [TW-1:0]       tmr_val, tmr_cnt;

  logic [IDX_W-1:0]    cur_inc;
  logic [N_LAYERS-1:0] cur_onehot, next_onehot;
  logic                done_cur;

  assign cur_inc = cur_q + IDX_W'(1);

  // One-hot decode of the current and the following layer index
  generate
    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_dec
      assign cur_onehot[gi]  = (cur_q == IDX_W'(gi));
      assign next_onehot[gi] = (cur_inc == IDX_W'(gi));
    end
  endgenerate

  // Only the current layer's done is ever looked at
  assign done_cur = |(layer_done & cur_onehot);

  seq_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Next-state and next-output decode; outputs change on state entry
  always_comb begin
    state_d       = state_q;
    layer_rst_d   = layer_rst_q;
    layer_start_d = '0;
    cur_d         = cur_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    err_d         = err_q;
    err_layer_d   = err_layer_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    tmr_inc       = 1'b0;
    tmr_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        layer_rst_d = '0;
        cur_d       = '0;
        busy_d      = 1'b0;
        if (frame_start) begin
          state_d        = RST;
          layer_rst_d    = '0;
          layer_rst_d[0] = 1'b1;
          busy_d         = 1'b1;
          tmr_load       = 1'b1;
          tmr_val        = RST_LOAD;
        end
      end
      RST: begin
        if (tmr_zero) begin
          state_d       = START;
          layer_rst_d   = '0;
          layer_start_d = cur_onehot;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      START: begin
        state_d  = RUN;
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
      RUN: begin
        if (done_cur) begin
          if (cur_q == LAST_LAYER) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d     = RST;
            cur_d       = cur_inc;
            layer_rst_d = next_onehot;
            tmr_load    = 1'b1;
            tmr_val     = RST_LOAD;
          end
        end else if (tmr_cnt == TO_LAST) begin
          state_d     = ERR;
          err_d       = 1'b1;
          err_layer_d = cur_q;
          layer_rst_d = '1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cur_d   = '0;
      end
      ERR: begin
        layer_rst_d = '1;
        if (err_clr) begin
          state_d     = IDLE;
          err_d       = 1'b0;
          busy_d      = 1'b0;
          layer_rst_d = '0;
          cur_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset holds every engine in soft reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      layer_rst_q   <= '1;
      layer_start_q <= '0;
      cur_q         <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      err_layer_q   <= '0;
    end else begin
      state_q       <= state_d;
      layer_rst_q   <= layer_rst_d;
      layer_start_q <= layer_start_d;
      cur_q         <= cur_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      err_layer_q   <= err_layer_d;
    end
  end

  assign layer_rst   = layer_rst_q;
  assign layer_start = layer_start_q;
  assign cur_layer   = cur_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
  assign err_layer   = err_layer_q;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Bench for cnn_layer_seq: a cycle model of the layer schedule, compared
// against the DUT on every falling edge, plus directed scenarios with
// hand-computed timing (frame-relative cycle numbers).
module tb_cnn_layer_seq;

  localparam int N  = 5;
  localparam int RC = 10;
  localparam int TO = 64;
  localparam int IW = 3;
  localparam int ENG_LAT = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  done_auto = '0;
  logic [N-1:0]  done_extra = '0;
  logic [N-1:0]  eng_en = '1;
  logic [N-1:0]  layer_done;
  logic [N-1:0]  layer_rst, layer_start;
  logic [IW-1:0] cur_layer, err_layer;
  logic          busy, frame_done, err;

  assign layer_done = done_auto | done_extra;

  cnn_layer_seq #(
    .N_LAYERS (N),
    .RST_CYC  (RC),
    .TIMEOUT  (TO),
    .IDX_W    (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .err_clr     (err_clr),
    .layer_done  (layer_done),
    .layer_rst   (layer_rst),
    .layer_start (layer_start),
    .cur_layer   (cur_layer),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err),
    .err_layer   (err_layer)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- schedule model ----------------
  // m_pre: just out of reset, engines still held; m_active: a frame is in
  // flight; m_rst_left: soft-reset cycles remaining for m_layer; m_start:
  // start pulse cycle; m_run: cycles spent waiting for done (-1 = not waiting).
  bit m_pre, m_active, m_start, m_fdone, m_err;
  int m_layer, m_rst_left, m_run, m_err_layer;

  task automatic m_reset();
    m_pre = 1; m_active = 0; m_start = 0; m_fdone = 0; m_err = 0;
    m_layer = 0; m_rst_left = 0; m_run = -1; m_err_layer = 0;
  endtask

  task automatic m_step(input bit fs, input bit ec, input logic [N-1:0] dn);
    m_pre = 0;
    if (m_err) begin
      if (ec) begin m_err = 0; m_layer = 0; end
    end else if (m_fdone) begin
      m_fdone = 0; m_active = 0; m_layer = 0;
    end else if (!m_active) begin
      if (fs) begin m_active = 1; m_layer = 0; m_rst_left = RC; end
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_start = 1;
    end else if (m_start) begin
      m_start = 0; m_run = 0;
    end else if (m_run >= 0) begin
      if (dn[m_layer]) begin
        m_run = -1;
        if (m_layer == N - 1) m_fdone = 1;
        else begin m_layer++; m_rst_left = RC; end
      end else if (m_run == TO - 1) begin
        m_run = -1; m_err = 1; m_err_layer = m_layer; m_active = 0;
      end else begin
        m_run++;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step(frame_start, err_clr, layer_done);
    end
  end

  // Compare process: every falling edge, all outputs against the model
  initial begin
    logic [N-1:0] e_rst, e_start;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_rst   = (m_pre || m_err) ? '1 : ((m_rst_left > 0) ? (N'(1) << m_layer) : '0);
        e_start = m_start ? (N'(1) << m_layer) : '0;
        check("m_layer_rst", layer_rst, e_rst);
        check("m_layer_start", layer_start, e_start);
        check("m_cur_layer", cur_layer, m_layer);
        check("m_busy", busy, m_active || m_err);
        check("m_frame_done", frame_done, m_fdone);
        check("m_err", err, m_err);
        check("m_err_layer", err_layer, m_err_layer);
      end
    end
  end

  // Engine model: enabled engines pulse done ENG_LAT cycles after start
  initial begin
    int ecnt [N];
    foreach (ecnt[i]) ecnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          ecnt[i] = 0; done_auto[i] = 1'b0;
        end else begin
          done_auto[i] = (ecnt[i] == 1);
          if (ecnt[i] > 0) ecnt[i]--;
          if (layer_start[i] && eng_en[i]) ecnt[i] = ENG_LAT;
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  // Starts a frame at the current falling edge and records frame-relative
  // timing. mode 4 injects spurious dones, mode 5 a mid-frame frame_start.
  task automatic run_frame(input int mode, output int t_s0, output int rst0,
                           output int t_fd, output int nfd, output int bz);
    t_s0 = -1; rst0 = 0; t_fd = -1; nfd = 0; bz = -1;
    frame_start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) frame_start = 1'b0;
      if (mode == 4) begin
        if (k == 35) done_extra = 5'b00011;
        if (k == 36) done_extra = '0;
        if (k == 50) done_extra = 5'b00100;
        if (k == 51) done_extra = '0;
      end
      if (mode == 5) begin
        if (k == 80) frame_start = 1'b1;
        if (k == 81) frame_start = 1'b0;
      end
      if (layer_rst[0] && !err) rst0++;
      if (layer_start[0] && t_s0 < 0) t_s0 = k;
      if (frame_done) begin nfd++; if (t_fd < 0) t_fd = k; end
      if (t_fd > 0 && k == t_fd + 1) bz = busy;
      if (t_fd > 0 && k == t_fd + 2) break;
    end
  endtask

  task automatic run_until_err(output int t_err);
    t_err = -1;
    frame_start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) frame_start = 1'b0;
      if (err) begin t_err = k; break; end
    end
  endtask

  initial begin
    int t_s0, rst0, t_fd, nfd, bz, t_err;

    // 1: reset, no stimulus
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_layer_rst", layer_rst, 5'b11111);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_layer_rst", layer_rst, 5'b00000);
    $display("[TB] reset: layer_rst=%b busy=%b err=%b", layer_rst, busy, err);
    repeat (2) @(negedge clk);

    // 2: normal frame
    run_frame(0, t_s0, rst0, t_fd, nfd, bz);
    check("f_start0_cycle", t_s0, 11);
    check("f_rst0_len", rst0, RC);
    check("f_fdone_cycle", t_fd, 156);
    check("f_fdone_count", nfd, 1);
    check("f_busy_after", bz, 0);
    $display("[TB] frame: start0=%0d rst0=%0d fdone=%0d", t_s0, rst0, t_fd);

    // 3: layer 2 hangs
    eng_en = 5'b11011;
    run_until_err(t_err);
    check("to_err_cycle", t_err, 138);
    check("to_err_layer", err_layer, 2);
    check("to_layer_rst", layer_rst, 5'b11111);
    check("to_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err, 1'b0);
    check("clr_busy", busy, 1'b0);
    check("clr_err_layer", err_layer, 2);
    $display("[TB] timeout: t_err=%0d err_layer=%0d", t_err, err_layer);
    eng_en = '1;
    repeat (2) @(negedge clk);

    // 4: spurious dones are ignored
    run_frame(4, t_s0, rst0, t_fd, nfd, bz);
    check("sp_fdone_cycle", t_fd, 156);
    check("sp_fdone_count", nfd, 1);
    $display("[TB] spurious done: fdone=%0d", t_fd);

    // 5a: frame_start while busy is dropped
    run_frame(5, t_s0, rst0, t_fd, nfd, bz);
    check("mid_fdone_cycle", t_fd, 156);
    repeat (3) @(negedge clk);
    check("mid_no_requeue", busy, 1'b0);
    $display("[TB] mid-frame start: fdone=%0d busy=%b", t_fd, busy);

    // 5b: frame_start together with err_clr in ERR
    eng_en = 5'b11011;
    run_until_err(t_err);
    eng_en = '1;
    frame_start = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clrfs_busy", busy, 1'b0);
    check("clrfs_layer_rst", layer_rst, 5'b00000);
    run_frame(0, t_s0, rst0, t_fd, nfd, bz);
    check("clrfs_next_fdone", t_fd, 156);
    $display("[TB] err_clr+frame_start: busy stayed low, next fdone=%0d", t_fd);

    // 6: async reset during layer 3 RUN
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (109) @(negedge clk);
    check("pre_cur_layer", cur_layer, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_layer_rst", layer_rst, 5'b11111);
    check("ar_busy", busy, 1'b0);
    check("ar_cur_layer", cur_layer, 0);
    check("ar_layer_start", layer_start, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, t_s0, rst0, t_fd, nfd, bz);
    check("ar_start0_cycle", t_s0, 11);
    check("ar_fdone_cycle", t_fd, 156);
    $display("[TB] async reset mid-run, then frame: fdone=%0d", t_fd);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
